// File: rtl/note_seq_pkg.sv
// note_seq_pkg
// Shared definitions for the note sequencer slice: the playback state
// enumeration and the default widths/depth used by note_seq_ctrl and
// note_seq_table.
// No ports (package).
package note_seq_pkg;

  localparam int DEF_BW    = 12;
  localparam int DEF_STEPS = 8;
  localparam int DEF_DUR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } note_state_e;

endpackage

// File: rtl/note_seq_table.sv
// note_seq_table
// Note table register file: STEPS entries of {period, duration}, one
// synchronous write port and one combinational read port. A synchronous
// reset clears every entry to period 0 / duration 0 (an end marker).
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   we_i, waddr_i         write enable and write address
//   wperiod_i, wdur_i     data to store
//   raddr_i               read address
//   rperiod_o, rdur_o     entry currently addressed by raddr_i
module note_seq_table
  import note_seq_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int STEPS = DEF_STEPS,
  parameter int DUR_W = DEF_DUR_W,
  localparam int AW   = $clog2(STEPS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [BW-1:0]    wperiod_i,
  input  logic [DUR_W-1:0] wdur_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [BW-1:0]    rperiod_o,
  output logic [DUR_W-1:0] rdur_o
);

  logic [BW+DUR_W-1:0] mem_q [STEPS];

  // Storage update. A write lands on the clock edge, so a read of the same
  // address in the same cycle still sees the previous contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= {wperiod_i, wdur_i};
    end
  end

  // Combinational read split back into the period and duration fields.
  always_comb begin
    rperiod_o = mem_q[raddr_i][BW+DUR_W-1:DUR_W];
    rdur_o    = mem_q[raddr_i][DUR_W-1:0];
  end

endmodule

// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl
// Note sequencer controller. Walks the note table from step 0, holding each
// note for its duration (counted in tick_i strobes) and presenting its
// period to an external tone counter. A duration of 0 marks the end of the
// sequence; reaching the last table step also ends it.
// Optional feature: define NOTE_SEQ_LOOP_EN to add loop_i, which restarts
// the sequence at step 0 instead of finishing.
// Ports:
//   clk_i, rst_i              clock and synchronous active-high reset
//   loop_i                    (NOTE_SEQ_LOOP_EN only) repeat the sequence
//   start_i, stop_i           start from step 0 (IDLE only) / abort anytime
//   tick_i                    duration time-base strobe
//   cfg_we_i, cfg_addr_i,
//   cfg_period_i, cfg_dur_i   note-table write port
//   period_o, tone_en_o       tone counter load value and enable
//   step_o, busy_o, done_o    current step, playback active, finish pulse
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int STEPS = DEF_STEPS,
  parameter int DUR_W = DEF_DUR_W,
  localparam int AW   = $clog2(STEPS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef NOTE_SEQ_LOOP_EN
  input  logic             loop_i,
`endif
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             tick_i,
  input  logic             cfg_we_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [BW-1:0]    cfg_period_i,
  input  logic [DUR_W-1:0] cfg_dur_i,
  output logic [BW-1:0]    period_o,
  output logic             tone_en_o,
  output logic [AW-1:0]    step_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [AW-1:0] LastStep = AW'(STEPS - 1);

  note_state_e      state_q;
  logic [AW-1:0]    step_q;
  logic [BW-1:0]    period_q;
  logic [DUR_W-1:0] durCnt_q;
  logic             toneEn_q;
  logic             busy_q;
  logic             done_q;

  logic [BW-1:0]    rdPeriod;
  logic [DUR_W-1:0] rdDur;
  logic             loopEn;

`ifdef NOTE_SEQ_LOOP_EN
  assign loopEn = loop_i;
`else
  assign loopEn = 1'b0;
`endif

  note_seq_table #(
    .BW    (BW),
    .STEPS (STEPS),
    .DUR_W (DUR_W)
  ) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (cfg_we_i),
    .waddr_i   (cfg_addr_i),
    .wperiod_i (cfg_period_i),
    .wdur_i    (cfg_dur_i),
    .raddr_i   (step_q),
    .rperiod_o (rdPeriod),
    .rdur_o    (rdDur)
  );

  // Playback FSM with every output registered alongside the state.
  // An end marker hit after step 0 reports the last step that actually
  // sounded and leaves period_o on that step's period, so the outputs after
  // completion describe the final note rather than the marker entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      period_q <= '0;
      durCnt_q <= '0;
      toneEn_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ST_LOAD;
            step_q  <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (stop_i) begin
            state_q  <= ST_IDLE;
            toneEn_q <= 1'b0;
            busy_q   <= 1'b0;
            durCnt_q <= '0;
          end else if (rdDur == '0) begin
            if (loopEn && (step_q != '0)) begin
              step_q <= '0;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (step_q != '0) begin
                step_q <= step_q - AW'(1);
              end
            end
          end else begin
            state_q  <= ST_PLAY;
            period_q <= rdPeriod;
            durCnt_q <= rdDur;
            toneEn_q <= (rdPeriod != '0);
          end
        end

        ST_PLAY: begin
          if (stop_i) begin
            state_q  <= ST_IDLE;
            toneEn_q <= 1'b0;
            busy_q   <= 1'b0;
            durCnt_q <= '0;
          end else if (tick_i && (durCnt_q != '0)) begin
            if (durCnt_q == DUR_W'(1)) begin
              durCnt_q <= '0;
              toneEn_q <= 1'b0;
              if (step_q == LastStep) begin
                if (loopEn) begin
                  state_q <= ST_LOAD;
                  step_q  <= '0;
                end else begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                state_q <= ST_LOAD;
                step_q  <= step_q + AW'(1);
              end
            end else begin
              durCnt_q <= durCnt_q - DUR_W'(1);
            end
          end
        end

        ST_DONE: begin
          state_q  <= ST_IDLE;
          toneEn_q <= 1'b0;
          busy_q   <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          toneEn_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign period_o  = period_q;
  assign tone_en_o = toneEn_q;
  assign step_o    = step_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// tb_note_seq_ctrl
// Self-checking bench for note_seq_ctrl. The reference model keeps a copy of
// the note table and predicts, from running duration sums, which note must
// be sounding after every tick and when the single done pulse must appear.
// Define NOTE_SEQ_LOOP_EN for both files to also exercise loop playback.
module tb_note_seq_ctrl;

  localparam int BW    = 12;
  localparam int STEPS = 8;
  localparam int DUR_W = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             loopI;
  logic             start;
  logic             stop;
  logic             tick;
  logic             cfgWe;
  logic [AW-1:0]    cfgAddr;
  logic [BW-1:0]    cfgPeriod;
  logic [DUR_W-1:0] cfgDur;
  logic [BW-1:0]    period;
  logic             toneEn;
  logic [AW-1:0]    step;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int mPer [STEPS];
  int mDur [STEPS];
  int expPeriod = 0;

  always #5 clk = ~clk;

  note_seq_ctrl #(
    .BW    (BW),
    .STEPS (STEPS),
    .DUR_W (DUR_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
`ifdef NOTE_SEQ_LOOP_EN
    .loop_i       (loopI),
`endif
    .start_i      (start),
    .stop_i       (stop),
    .tick_i       (tick),
    .cfg_we_i     (cfgWe),
    .cfg_addr_i   (cfgAddr),
    .cfg_period_i (cfgPeriod),
    .cfg_dur_i    (cfgDur),
    .period_o     (period),
    .tone_en_o    (toneEn),
    .step_o       (step),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Count done pulses on the falling edge, half a cycle away from updates.
  always @(negedge clk) begin
    if (done === 1'b1) doneCnt++;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input int a, input int p, input int d);
    cfgWe     = 1'b1;
    cfgAddr   = a[AW-1:0];
    cfgPeriod = p[BW-1:0];
    cfgDur    = d[DUR_W-1:0];
    cyc(1);
    cfgWe     = 1'b0;
    mPer[a]   = p;
    mDur[a]   = d;
  endtask

  // Start playback and follow it tick by tick against the model. Ticks are
  // four clocks apart. stopAt >= 0 aborts with stop_i after that many ticks.
  task automatic playTable(input string tag, input int stopAt);
    int n;
    int total;
    int cum [STEPS];
    int k;
    int base;
    n = 0;
    total = 0;
    while (n < STEPS && mDur[n] != 0) begin
      total += mDur[n];
      cum[n] = total;
      n++;
    end
    base = doneCnt;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    if (n == 0) begin
      cyc(1);
      checks++;
      if (doneCnt !== base + 1) begin
        errors++;
        $display("[TB] FAIL %s empty_done: got %0d pulses expected 1", tag, doneCnt - base);
      end
      checks++;
      if (busy !== 1'b0 || toneEn !== 1'b0 || step !== '0 || period !== BW'(expPeriod)) begin
        errors++;
        $display("[TB] FAIL %s empty_outputs: got busy=%0b tone=%0b step=%0d period=%0d expected 0/0/0/%0d",
                 tag, busy, toneEn, step, period, expPeriod);
      end
      return;
    end
    for (int j = 0; j <= total; j++) begin
      if (j > 0) begin
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
      end
      if (j < total) begin
        k = 0;
        while (cum[k] <= j) k++;
        expPeriod = mPer[k];
        checks++;
        if (step !== AW'(k)) begin
          errors++;
          $display("[TB] FAIL %s step@tick%0d: got %0d expected %0d", tag, j, step, k);
        end
        checks++;
        if (period !== BW'(mPer[k])) begin
          errors++;
          $display("[TB] FAIL %s period@tick%0d: got %0d expected %0d", tag, j, period, mPer[k]);
        end
        checks++;
        if (toneEn !== (mPer[k] != 0) || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s tone_busy@tick%0d: got %0b/%0b expected %0b/1", tag, j, toneEn, busy, mPer[k] != 0);
        end
        checks++;
        if (doneCnt !== base) begin
          errors++;
          $display("[TB] FAIL %s early_done@tick%0d: got %0d pulses expected 0", tag, j, doneCnt - base);
        end
        if (j == stopAt) begin
          stop = 1'b1;
          cyc(1);
          stop = 1'b0;
          checks++;
          if (busy !== 1'b0 || toneEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s stop_idle: got busy=%0b tone=%0b expected 0/0", tag, busy, toneEn);
          end
          cyc(3);
          checks++;
          if (doneCnt !== base || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s stop_no_done: got %0d pulses busy=%0b expected 0 pulses busy=0", tag, doneCnt - base, busy);
          end
          return;
        end
      end else begin
        checks++;
        if (doneCnt !== base + 1) begin
          errors++;
          $display("[TB] FAIL %s done_pulses: got %0d expected 1", tag, doneCnt - base);
        end
        checks++;
        if (busy !== 1'b0 || toneEn !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s end_idle: got busy=%0b tone=%0b expected 0/0", tag, busy, toneEn);
        end
        checks++;
        if (step !== AW'(n - 1) || period !== BW'(expPeriod)) begin
          errors++;
          $display("[TB] FAIL %s end_hold: got step=%0d period=%0d expected %0d/%0d", tag, step, period, n - 1, expPeriod);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    checks++;
    if (period !== '0 || toneEn !== 1'b0 || step !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got period=%0d tone=%0b step=%0d busy=%0b done=%0b expected all 0",
               period, toneEn, step, busy, done);
    end
    rst = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      mPer[i] = 0;
      mDur[i] = 0;
    end
    expPeriod = 0;
    cyc(1);
  endtask

  task automatic test_basic();
    writeEntry(0, 100, 2);
    writeEntry(1, 0, 1);
    writeEntry(2, 200, 3);
    writeEntry(3, 0, 0);
    playTable("basic", -1);
  endtask

  task automatic test_full();
    for (int i = 0; i < STEPS; i++) writeEntry(i, $urandom_range(1, 4095), 1);
    playTable("full", -1);
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_busy_after: got %0b expected 0", busy);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < STEPS; i++) begin
        writeEntry(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095),
                   ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3));
      end
      tick = 1'b1;
      cyc(2);
      tick = 1'b0;
      playTable("random", -1);
    end
  endtask

  task automatic test_stop();
    writeEntry(0, 300, 1);
    writeEntry(1, 400, 2);
    writeEntry(2, 500, 1);
    writeEntry(3, 0, 0);
    playTable("stop", 1);
    playTable("replay", -1);
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_stop_busy: got %0b expected 0", busy);
    end
    cyc(2);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_stop_stay_idle: got busy=%0b done=%0b expected 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    writeEntry(0, 700, 3);
    writeEntry(1, 0, 0);
    base = doneCnt;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++;
    if (period !== '0 || toneEn !== 1'b0 || step !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got period=%0d tone=%0b step=%0d busy=%0b done=%0b expected all 0",
               period, toneEn, step, busy, done);
    end
    checks++;
    if (doneCnt !== base) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_done: got %0d pulses expected 0", doneCnt - base);
    end
    for (int i = 0; i < STEPS; i++) begin
      mPer[i] = 0;
      mDur[i] = 0;
    end
    expPeriod = 0;
    playTable("after_reset", -1);
  endtask

  task automatic test_write_during_play();
    int base;
    writeEntry(0, 111, 2);
    writeEntry(1, 222, 1);
    writeEntry(2, 0, 0);
    base = doneCnt;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    writeEntry(1, 333, 1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cfgWe     = 1'b1;
    cfgAddr   = 3'd1;
    cfgPeriod = 12'd444;
    cfgDur    = 8'd1;
    cyc(1);
    cfgWe = 1'b0;
    checks++;
    if (step !== 3'd1 || period !== 12'd333 || toneEn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_load_old: got step=%0d period=%0d tone=%0b expected 1/333/1", step, period, toneEn);
    end
    mPer[1] = 444;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
    checks++;
    if (doneCnt !== base + 1 || period !== 12'd333) begin
      errors++;
      $display("[TB] FAIL write_done: got %0d pulses period=%0d expected 1/333", doneCnt - base, period);
    end
    expPeriod = 333;
    playTable("write_new", -1);
  endtask

`ifdef NOTE_SEQ_LOOP_EN
  task automatic test_loop();
    int base;
    int k;
    writeEntry(0, 50, 2);
    writeEntry(1, 60, 2);
    writeEntry(2, 0, 0);
    base = doneCnt;
    loopI = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) begin
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
      end
      if (j < 12) begin
        k = ((j % 4) < 2) ? 0 : 1;
        checks++;
        if (step !== AW'(k) || period !== BW'(mPer[k]) || busy !== 1'b1 || doneCnt !== base) begin
          errors++;
          $display("[TB] FAIL loop@tick%0d: got step=%0d period=%0d busy=%0b pulses=%0d expected %0d/%0d/1/0",
                   j, step, period, busy, doneCnt - base, k, mPer[k]);
        end
      end else begin
        checks++;
        if (doneCnt !== base + 1 || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL loop_off_done: got %0d pulses busy=%0b expected 1/0", doneCnt - base, busy);
        end
      end
      if (j == 9) loopI = 1'b0;
    end
    expPeriod = 60;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    loopI     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    tick      = 1'b0;
    cfgWe     = 1'b0;
    cfgAddr   = '0;
    cfgPeriod = '0;
    cfgDur    = '0;
    test_reset();
    test_basic();
    test_full();
    test_stop();
    test_start_stop();
    test_write_during_play();
    test_random();
`ifdef NOTE_SEQ_LOOP_EN
    test_loop();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_seq_ctrl.md
NOTE_SEQ_CTRL -- requirements
Module: note_seq_ctrl

Interface
REQ-001 Parameter BW, default 12: width of tone-counter period word.
REQ-002 Parameter STEPS, default 8: note-table depth; AW = $clog2(STEPS).
REQ-003 Parameter DUR_W, default 8: width of per-step duration field.
REQ-004 clk_i  input  1  sole clock, rising edge.
REQ-005 rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 start_i  input  1  start playback at step 0; honoured only in IDLE.
REQ-007 stop_i  input  1  abort playback; honoured in any state.
REQ-008 tick_i  input  1  one-cycle duration time-base strobe.
REQ-009 cfg_we_i  input  1  note-table write enable.
REQ-010 cfg_addr_i  input  AW  note-table write address.
REQ-011 cfg_period_i  input  BW  period to store; 0 = rest.
REQ-012 cfg_dur_i  input  DUR_W  duration in ticks to store; 0 = end marker.
REQ-013 period_o  output  BW  period load value for the tone counter.
REQ-014 tone_en_o  output  1  tone counter enable; 1 only in PLAY with period_o != 0.
REQ-015 step_o  output  AW  current step index.
REQ-016 busy_o  output  1  high in LOAD and PLAY.
REQ-017 done_o  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-018 FSM states: IDLE, LOAD, PLAY, DONE; all outputs registered.
REQ-019 IDLE: start_i=1 and stop_i=0 -> LOAD next cycle, step_o=0; start_i while busy ignored.
REQ-020 LOAD (one cycle): period_o and duration counter loaded from table[step_o]; if dur==0 -> DONE instead of PLAY.
REQ-021 PLAY: duration counter decrements by 1 on each tick_i; tick_i with count==1 ends the step.
REQ-022 Step end: step_o==STEPS-1 -> DONE; else step_o+1 and LOAD next cycle.
REQ-023 DONE: done_o=1 for exactly one cycle, tone_en_o=0, then IDLE; period_o holds last value.
REQ-024 stop_i in LOAD/PLAY/DONE -> IDLE next cycle, tone_en_o=0, busy_o=0, no done_o pulse.
REQ-025 start_i and stop_i same cycle in IDLE: stop wins, stay IDLE.
REQ-026 Table writes accepted in every state, take effect at next LOAD of that address; write and LOAD of same address same cycle: LOAD reads old value.
REQ-027 tick_i in IDLE, LOAD, DONE ignored; duration counter never wraps below 0.
REQ-028 Step index wraps only under REQ-033; otherwise never exceeds STEPS-1.

Reset
REQ-029 rst_i=1 at clock edge: FSM -> IDLE, period_o=0, tone_en_o=0, step_o=0, busy_o=0, done_o=0, duration counter=0.
REQ-030 Reset clears every table entry to period 0, dur 0.
REQ-031 Reset mid-playback aborts immediately; no done_o pulse; first post-reset cycle obeys IDLE rules.

Configuration
REQ-032 Macro NOTE_SEQ_LOOP_EN adds input loop_i (1 bit).
REQ-033 With NOTE_SEQ_LOOP_EN and loop_i=1: step end at STEPS-1, or dur==0 at a step >0, -> LOAD at step 0, no done_o; dur==0 at step 0 -> DONE.
REQ-034 Without NOTE_SEQ_LOOP_EN: no loop_i port; behaviour exactly REQ-018..028.

Structure
REQ-035 Package note_seq_pkg holds the state enum typedef and default BW/STEPS/DUR_W constants.
REQ-036 Sub-module note_seq_table: STEPS x (BW+DUR_W) register file, one write port, one combinational read port, synchronous reset clear.

Verification
REQ-037 Write steps 0..2 = (100,2),(0,1),(200,3), step3 dur 0; start; tick every 4 clks -> period_o 100/0/200, tone_en_o 1/0/1, done_o after 6 ticks, step_o ends 2.
REQ-038 Fill all 8 steps dur 1; start -> step_o 0..7, one done_o pulse, busy_o low the cycle after DONE.
REQ-039 stop_i during PLAY step 1 -> IDLE next cycle, tone_en_o=0, no done_o; later start_i replays from step 0.
REQ-040 start_i and stop_i together in IDLE -> busy_o stays 0; rst_i mid-PLAY -> all outputs 0, table read back all zero.
REQ-041 Write step 1 while step 0 plays -> new value appears at step 1 LOAD; write same address during its LOAD -> old value used.
REQ-042 NOTE_SEQ_LOOP_EN, loop_i=1, steps 0,1 dur 2, step2 dur 0 -> step_o 0,1,0,1..., no done_o; loop_i=0 -> done_o after step 1.
